// File: rtl/div_pkg.sv
// Shared types, widths and helpers for the 32-bit sequential divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH   = 32;
    localparam int unsigned COUNT_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } div_state_e;

    // Two's-complement negate when en is set, pass-through otherwise.
    function automatic logic [DIV_WIDTH-1:0] neg_if(input logic en, input logic [DIV_WIDTH-1:0] x);
        return en ? DIV_WIDTH'(~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/seq_divider_32_if.sv
// Request/result bundle between a requester and the sequential divider.
interface seq_divider_32_if;
    import div_pkg::*;

    logic                 start;
    logic                 signed_op;
    logic [DIV_WIDTH-1:0] dividend;
    logic [DIV_WIDTH-1:0] divisor;
    logic [DIV_WIDTH-1:0] quotient;
    logic [DIV_WIDTH-1:0] remainder;
    logic                 busy;
    logic                 done;
    logic                 div_by_zero;

    modport master (
        output start, signed_op, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );

endinterface

// File: rtl/cla_sub_4bit.sv
// 4-bit carry-lookahead slice computing a + ~b + cin (subtract with carry-in).
module cla_sub_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] diff,
    output logic       cout
);

    logic [3:0] b_n;
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign b_n = ~b;
    assign g   = a & b_n;
    assign p   = a ^ b_n;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign diff = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/seq_divider_32.sv
// 32-bit restoring divider, one quotient bit per cycle, signed/unsigned,
// with divide-by-zero reported as all-ones quotient and original dividend.
module seq_divider_32
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    seq_divider_32_if.slave bus
);

    localparam int unsigned SUB_WIDTH = 36;
    localparam int unsigned SLICES    = SUB_WIDTH / 4;

    div_state_e             state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [DIV_WIDTH-1:0]   rem_q, rem_d;
    logic [DIV_WIDTH-1:0]   quo_q, quo_d;
    logic [DIV_WIDTH-1:0]   dvsr_q, dvsr_d;
    logic                   quo_neg_q, quo_neg_d;
    logic                   rem_neg_q, rem_neg_d;
    logic [DIV_WIDTH-1:0]   quotient_q, quotient_d;
    logic [DIV_WIDTH-1:0]   remainder_q, remainder_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   dbz_q, dbz_d;

    logic                   dend_neg_c;
    logic                   dvsr_neg_c;
    logic [DIV_WIDTH-1:0]   dend_mag_c;
    logic [DIV_WIDTH-1:0]   dvsr_mag_c;

    logic [DIV_WIDTH:0]     rem_shift;
    logic [SUB_WIDTH-1:0]   sub_a;
    logic [SUB_WIDTH-1:0]   sub_b;
    logic [SUB_WIDTH-1:0]   diff;
    logic [SLICES:0]        carry;
    logic                   trial_ok;

    // Operand magnitudes and signs seen at the start edge.
    assign dend_neg_c = bus.signed_op & bus.dividend[DIV_WIDTH-1];
    assign dvsr_neg_c = bus.signed_op & bus.divisor[DIV_WIDTH-1];
    assign dend_mag_c = neg_if(dend_neg_c, bus.dividend);
    assign dvsr_mag_c = neg_if(dvsr_neg_c, bus.divisor);

    // Trial subtract of the shifted partial remainder, zero-extended to 36 bits.
    assign rem_shift = {rem_q, quo_q[DIV_WIDTH-1]};
    assign sub_a     = SUB_WIDTH'(rem_shift);
    assign sub_b     = SUB_WIDTH'(dvsr_q);
    assign carry[0]  = 1'b1;

    for (genvar i = 0; i < SLICES; i++) begin : g_sub
        cla_sub_4bit u_slice (
            .a    (sub_a[4*i +: 4]),
            .b    (sub_b[4*i +: 4]),
            .cin  (carry[i]),
            .diff (diff[4*i +: 4]),
            .cout (carry[i+1])
        );
    end

    // No borrow out means the difference is non-negative; upper bits are zero then.
    assign trial_ok = carry[SLICES] & ~(|diff[SUB_WIDTH-1:DIV_WIDTH]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        quo_neg_d   = quo_neg_q;
        rem_neg_d   = rem_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rem_d     = '0;
                    quo_d     = dend_mag_c;
                    dvsr_d    = dvsr_mag_c;
                    quo_neg_d = dend_neg_c ^ dvsr_neg_c;
                    rem_neg_d = dend_neg_c;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    state_d   = (dvsr_mag_c == '0) ? FIXUP : RUN;
                end
            end
            RUN: begin
                rem_d   = trial_ok ? diff[DIV_WIDTH-1:0] : rem_shift[DIV_WIDTH-1:0];
                quo_d   = {quo_q[DIV_WIDTH-2:0], trial_ok};
                count_d = COUNT_WIDTH'(count_q + 1'b1);
                busy_d  = 1'b1;
                if (count_q == COUNT_WIDTH'(DIV_WIDTH - 1)) state_d = FIXUP;
            end
            FIXUP: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (dvsr_q == '0) begin
                    // quo still holds the dividend magnitude; restore its sign.
                    quotient_d  = '1;
                    remainder_d = neg_if(rem_neg_q, quo_q);
                    dbz_d       = 1'b1;
                end else begin
                    quotient_d  = neg_if(quo_neg_q, quo_q);
                    remainder_d = neg_if(rem_neg_q, rem_q);
                    dbz_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            quo_neg_q   <= quo_neg_d;
            rem_neg_q   <= rem_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_32.sv
// Bench for seq_divider_32: directed vector table, hand-written corner sequences,
// and random operations against an arithmetic reference.
module tb_seq_divider_32;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    seq_divider_32_if bus ();

    seq_divider_32 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero when signed.
    function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (s) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            z = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Present operands, pulse start across one edge, then scramble the inputs.
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        bus.signed_op = s;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.signed_op = 1'($urandom);
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
    endtask

    // Count edges until done; busy samples include the one right after the start edge.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = int'(bus.busy);
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            busy_cnt += int'(bus.busy);
        end
        chk("done_timeout", 32'(bus.done), 32'd1);
    endtask

    initial begin
        int          lat;
        int          bcnt;
        int          seen;
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        logic        rs;
        logic [31:0] ra;
        logic [31:0] rb;

        errors        = 0;
        checks        = 0;
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;

        vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        1'b0, 33};
        vecs[1] = '{1'b1, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33};
        vecs[2] = '{1'b1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,        1'b0, 33};
        vecs[3] = '{1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        1'b1, 1};
        vecs[4] = '{1'b1, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        1'b1, 1};
        vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0, 33};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,        1'b0, 33};
        vecs[7] = '{1'b1, 32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1};
        vecs[8] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,       32'hFFFF_FFFE, 1'b0, 33};
        vecs[9] = '{1'b0, 32'hFFFF_FF9C,  32'd7,        32'h2492_4916, 32'd2,        1'b0, 33};

        #2;
        chk("rst_quotient",  bus.quotient,            32'd0);
        chk("rst_remainder", bus.remainder,           32'd0);
        chk("rst_busy",      32'(bus.busy),           32'd0);
        chk("rst_done",      32'(bus.done),           32'd0);
        chk("rst_dbz",       32'(bus.div_by_zero),    32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].s, vecs[i].a, vecs[i].b);
            wait_done(lat, bcnt);
            chk($sformatf("vec%0d_quotient", i),  bus.quotient,         vecs[i].q);
            chk($sformatf("vec%0d_remainder", i), bus.remainder,        vecs[i].r);
            chk($sformatf("vec%0d_dbz", i),       32'(bus.div_by_zero), 32'(vecs[i].z));
            chk($sformatf("vec%0d_latency", i),   32'(lat),             32'(vecs[i].lat));
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt),          32'(vecs[i].lat));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_width", i), 32'(bus.done), 32'd0);
        end

        // Start pulsed mid-run is ignored; back-to-back start after done is accepted.
        launch(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        launch(1'b1, 32'd9, 32'd3);
        wait_done(lat, bcnt);
        chk("ignore_quotient",  bus.quotient,  32'd14);
        chk("ignore_remainder", bus.remainder, 32'd2);
        chk("ignore_latency",   32'(lat + 10), 32'd33);
        launch(1'b0, 32'd1000, 32'd10);
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        wait_done(lat, bcnt);
        chk("b2b_quotient",  bus.quotient,  32'd100);
        chk("b2b_remainder", bus.remainder, 32'd0);
        chk("b2b_latency",   32'(lat),      32'd33);

        // Reset during RUN clears outputs at once and suppresses done.
        @(posedge clk);
        #1;
        launch(1'b0, 32'd77, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_quotient",  bus.quotient,         32'd0);
        chk("midrst_remainder", bus.remainder,        32'd0);
        chk("midrst_busy",      32'(bus.busy),        32'd0);
        chk("midrst_done",      32'(bus.done),        32'd0);
        chk("midrst_dbz",       32'(bus.div_by_zero), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen  = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen += int'(bus.done) + int'(bus.busy);
        end
        chk("midrst_no_done", 32'(seen), 32'd0);
        launch(1'b0, 32'd9, 32'd3);
        wait_done(lat, bcnt);
        chk("post_rst_quotient",  bus.quotient,  32'd3);
        chk("post_rst_remainder", bus.remainder, 32'd0);
        chk("post_rst_latency",   32'(lat),      32'd33);

        for (int n = 0; n < 40; n++) begin
            rs = 1'($urandom);
            ra = $urandom;
            case ($urandom_range(7, 0))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(15, 1));
                3:       rb = 32'(-$signed(32'($urandom_range(15, 1))));
                default: rb = $urandom;
            endcase
            if (n == 0) begin
                rs = 1'b1;
                ra = 32'h8000_0000;
                rb = 32'd1;
            end
            model(rs, ra, rb, eq, er, ez);
            @(posedge clk);
            #1;
            launch(rs, ra, rb);
            wait_done(lat, bcnt);
            chk($sformatf("rnd%0d_quotient", n),  bus.quotient,         eq);
            chk($sformatf("rnd%0d_remainder", n), bus.remainder,        er);
            chk($sformatf("rnd%0d_dbz", n),       32'(bus.div_by_zero), 32'(ez));
            chk($sformatf("rnd%0d_latency", n),   32'(lat),             ez ? 32'd1 : 32'd33);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_divider_32.md
SEQ_DIVIDER_32 -- requirements
Module: seq_divider_32

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock.
REQ-002 SHALL: reset  input  1  asynchronous, active-low; clock clk.
REQ-003 SHALL: start  input  1  request, sampled only in IDLE.
REQ-004 SHALL: signed_op  input  1  1 = two's-complement divide, 0 = unsigned; captured with start.
REQ-005 SHALL: dividend  input  32  numerator; captured with start.
REQ-006 SHALL: divisor  input  32  denominator; captured with start.
REQ-007 SHALL: quotient  output  32  registered result; held until next completion.
REQ-008 SHALL: remainder  output  32  registered result; held until next completion.
REQ-009 SHALL: busy  output  1  high in RUN and FIXUP.
REQ-010 SHALL: done  output  1  single-cycle pulse when quotient/remainder update.
REQ-011 SHALL: div_by_zero  output  1  flag for last completed op; updates with done.

Function
REQ-012 SHALL use FSM states IDLE, RUN, FIXUP, with IDLE as the reset state.
REQ-013 SHALL, at an edge in IDLE with start=1, capture |dividend| and |divisor| (magnitudes only when signed_op=1), record result signs, clear the 6-bit iteration counter, and go to RUN (call this edge E0).
REQ-014 SHALL, when the captured divisor is zero, go from E0 directly to FIXUP and skip RUN.
REQ-015 SHALL, in RUN, perform one restoring step per cycle: shift {rem,quo} left 1; do a 33-bit trial subtract rem - divisor; if non-negative, keep the difference and set quo LSB = 1, else restore and set LSB = 0.
REQ-016 SHALL leave RUN for FIXUP after exactly 32 steps (edges E1..E32).
REQ-017 SHALL, at the FIXUP edge, write quotient/remainder, assert done for exactly one cycle, then return to IDLE.
REQ-018 SHALL give a latency for non-zero divisor of start edge E0 to done high after E33, i.e. 33 cycles; for a zero divisor, done high after E1.
REQ-019 SHALL, when signed_op=1, negate the quotient when sign(dividend) XOR sign(divisor) = 1, and give the remainder the sign of the dividend.
REQ-020 SHALL, on divide by zero, output quotient = 0xFFFFFFFF and remainder = original dividend for both signed and unsigned, with div_by_zero = 1.
REQ-021 SHALL, for signed overflow 0x80000000 / 0xFFFFFFFF, output quotient = 0x80000000, remainder = 0, div_by_zero = 0, with no special path.
REQ-022 SHALL ignore start while busy=1; inputs changing during RUN have no effect.
REQ-023 SHALL accept start in the IDLE cycle immediately following the done pulse (back-to-back ops).

Reset
REQ-024 SHALL, on reset low, immediately force state=IDLE, counter=0, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0.
REQ-025 SHALL make reset asserted mid-RUN abort the operation with no done pulse; the first start after reset release SHALL behave normally.

Structure
REQ-026 SHALL place the state enum typedef, DIV_WIDTH=32, and COUNT_WIDTH=6 in shared package div_pkg.
REQ-027 SHALL build the 33-bit trial subtractor from nine instances of sub-module cla_sub_4bit (a 4-bit carry-lookahead a+~b+cin slice with generate/propagate carries), rippling between slices, with operands zero-extended to 36 bits.
REQ-028 SHALL keep the datapath unpipelined: one trial subtract per cycle, all state in flops clocked by clk.

Verification
REQ-029 SHALL cover: unsigned 100/7 -> quotient=14, remainder=2, done exactly 33 cycles after start edge, busy high 33 cycles.
REQ-030 SHALL cover: signed -100/7 (0xFFFFFF9C/7) -> quotient=0xFFFFFFF2, remainder=0xFFFFFFFE; signed 100/-7 -> quotient=0xFFFFFFF2, remainder=2.
REQ-031 SHALL cover: 5/0 (both modes) -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, done 1 cycle after start edge.
REQ-032 SHALL cover: signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0; unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
REQ-033 SHALL cover: start pulsed at step 10 with different operands -> ignored, first result unchanged; new start on the cycle after done -> accepted.
REQ-034 SHALL cover: reset asserted at step 10 -> all outputs 0 immediately, no done; after release 9/3 -> quotient=3, remainder=0.
